// File: rtl/uart_pio_mailbox.sv
// uart_pio_mailbox: bridges HPS PIO command/data exports to CHANNELS fabric
// byte streams, each with its own show-ahead TX FIFO and RX FIFO.
//
// Ports
//   clk_clk, reset_reset_n    : clock shared with the HPS PIO, async active-low reset
//   pio_addr                  : channel select (>= CHANNELS is flagged as bad address)
//   pio_wdata                 : byte queued into TX FIFO[addr] on a write toggle
//   pio_cmd[2:0]              : toggle commands {clear-ovf, read, write}
//   pio_rdata                 : byte popped by the last read toggle (0 if RX was empty)
//   pio_status[4:0]           : {bad_addr, ovf, tx_full, rx_nonempty, ack toggle}
//   irq                       : high while any RX FIFO holds data
//   tx_data/tx_valid/tx_ready : per-channel TX streams, channel i at [i*DATA_W +: DATA_W]
//   rx_data/rx_valid          : per-channel RX strobes, no backpressure
module uart_pio_mailbox #(
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 2
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset_n,
   input  logic [ADDR_W-1:0]            pio_addr,
   input  logic [DATA_W-1:0]            pio_wdata,
   input  logic [2:0]                   pio_cmd,
   output logic [DATA_W-1:0]            pio_rdata,
   output logic [4:0]                   pio_status,
   output logic                         irq,
   output logic [CHANNELS*DATA_W-1:0]   tx_data,
   output logic [CHANNELS-1:0]          tx_valid,
   input  logic [CHANNELS-1:0]          tx_ready,
   input  logic [CHANNELS*DATA_W-1:0]   rx_data,
   input  logic [CHANNELS-1:0]          rx_valid
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W+1)'(CHANNELS);

   // Command history and edge detection
   logic [2:0]          cmd_hist;
   logic                primed;
   logic [2:0]          cmd_edge;
   logic                addr_ok;

   // Per-channel status, current and post-update
   logic [CHANNELS-1:0] ch_sel;
   logic [CHANNELS-1:0] rx_ne_cur;
   logic [CHANNELS-1:0] rx_ne_nxt;
   logic [CHANNELS-1:0] tx_full_nxt;
   logic [CHANNELS-1:0] ovf_nxt;
   logic [DATA_W-1:0]   rx_head [CHANNELS];

   // Values of the addressed channel
   logic                sel_rx_ne_cur;
   logic                sel_rx_ne_nxt;
   logic                sel_tx_full_nxt;
   logic                sel_ovf_nxt;
   logic [DATA_W-1:0]   sel_head;

   // Registered HPS-facing outputs
   logic                ack_q;
   logic                bad_q;
   logic [2:0]          flags_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                irq_q;

   // No command executes until the history register has captured pio_cmd once.
   assign cmd_edge = primed ? (pio_cmd ^ cmd_hist) : 3'b000;
   assign addr_ok  = ({1'b0, pio_addr} < ADDR_LIM);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
      logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  tx_wp, tx_rp, rx_wp, rx_rp;
      logic [CNT_W-1:0]  tx_cnt, rx_cnt;
      logic [CNT_W-1:0]  tx_cnt_nxt, rx_cnt_nxt;
      logic              ovf;
      logic              wr_req, rd_req, clr_req;
      logic              tx_full, rx_full;
      logic              tx_pop, tx_push, rx_pop, rx_push;
      logic              ovf_set;

      assign ch_sel[i] = addr_ok && (pio_addr == ADDR_W'(i));
      assign wr_req    = cmd_edge[0] && ch_sel[i];
      assign rd_req    = cmd_edge[1] && ch_sel[i];
      assign clr_req   = cmd_edge[2] && ch_sel[i];

      assign tx_full   = (tx_cnt == CNT_FULL);
      assign rx_full   = (rx_cnt == CNT_FULL);

      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      assign tx_pop    = (tx_cnt != '0) && tx_ready[i];
      assign tx_push   = wr_req && (!tx_full || tx_pop);
      assign rx_pop    = rd_req && (rx_cnt != '0);
      assign rx_push   = rx_valid[i] && (!rx_full || rx_pop);

      // Overflow set beats a same-cycle clear.
      assign ovf_set    = (wr_req && tx_full && !tx_pop) || (rx_valid[i] && rx_full && !rx_pop);
      assign ovf_nxt[i] = ovf_set || (ovf && !clr_req);

      // Occupancy after this cycle's push/pop
      always_comb begin
         tx_cnt_nxt = tx_cnt;
         rx_cnt_nxt = rx_cnt;
         if (tx_push && !tx_pop) begin
            tx_cnt_nxt = tx_cnt + CNT_ONE;
         end else if (!tx_push && tx_pop) begin
            tx_cnt_nxt = tx_cnt - CNT_ONE;
         end
         if (rx_push && !rx_pop) begin
            rx_cnt_nxt = rx_cnt + CNT_ONE;
         end else if (!rx_push && rx_pop) begin
            rx_cnt_nxt = rx_cnt - CNT_ONE;
         end
      end

      assign rx_ne_cur[i]   = (rx_cnt != '0);
      assign rx_ne_nxt[i]   = (rx_cnt_nxt != '0);
      assign tx_full_nxt[i] = (tx_cnt_nxt == CNT_FULL);
      assign rx_head[i]     = rx_mem[rx_rp];

      // Show-ahead TX: head is presented while the FIFO holds data
      assign tx_valid[i]                   = (tx_cnt != '0);
      assign tx_data[i*DATA_W +: DATA_W]   = tx_mem[tx_rp];

      // Storage arrays carry no reset; validity comes from the counters.
      always_ff @(posedge clk_clk) begin
         if (tx_push) begin
            tx_mem[tx_wp] <= pio_wdata;
         end
         if (rx_push) begin
            rx_mem[rx_wp] <= rx_data[i*DATA_W +: DATA_W];
         end
      end

      // Pointers, counters and overflow sticky
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            ovf    <= 1'b0;
         end else begin
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            tx_cnt <= tx_cnt_nxt;
            rx_cnt <= rx_cnt_nxt;
            ovf    <= ovf_nxt[i];
         end
      end
   end

   // Select the addressed channel's values; a bad address reads as all zero.
   always_comb begin
      sel_rx_ne_cur   = 1'b0;
      sel_rx_ne_nxt   = 1'b0;
      sel_tx_full_nxt = 1'b0;
      sel_ovf_nxt     = 1'b0;
      sel_head        = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (ch_sel[c]) begin
            sel_rx_ne_cur   = rx_ne_cur[c];
            sel_rx_ne_nxt   = rx_ne_nxt[c];
            sel_tx_full_nxt = tx_full_nxt[c];
            sel_ovf_nxt     = ovf_nxt[c];
            sel_head        = rx_head[c];
         end
      end
   end

   // HPS-facing registers; status reflects state after this cycle's updates.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cmd_hist <= 3'b000;
         primed   <= 1'b0;
         ack_q    <= 1'b0;
         bad_q    <= 1'b0;
         flags_q  <= 3'b000;
         rdata_q  <= '0;
         irq_q    <= 1'b0;
      end else begin
         cmd_hist <= pio_cmd;
         primed   <= 1'b1;
         if (|cmd_edge) begin
            ack_q <= ~ack_q;
            bad_q <= ~addr_ok;
         end
         if (cmd_edge[1] && addr_ok) begin
            rdata_q <= sel_rx_ne_cur ? sel_head : '0;
         end
         flags_q <= {sel_ovf_nxt, sel_tx_full_nxt, sel_rx_ne_nxt};
         irq_q   <= |rx_ne_nxt;
      end
   end

   assign pio_status = {bad_q, flags_q, ack_q};
   assign pio_rdata  = rdata_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_uart_pio_mailbox.sv
module tb_uart_pio_mailbox;

   localparam int NCH   = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [AW-1:0]     addr = '0;
   logic [DW-1:0]     wdata = '0;
   logic [2:0]        cmd = 3'b011;
   logic [DW-1:0]     pio_rdata;
   logic [4:0]        pio_status;
   logic              irq;
   logic [NCH*DW-1:0] tx_data;
   logic [NCH-1:0]    tx_valid;
   logic [NCH-1:0]    tx_ready = '0;
   logic [NCH*DW-1:0] rx_data = '0;
   logic [NCH-1:0]    rx_valid = '0;

   int n_cmp  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;
   logic ack_lit = 1'b0;

   uart_pio_mailbox #(.CHANNELS(NCH), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .pio_addr(addr), .pio_wdata(wdata), .pio_cmd(cmd),
      .pio_rdata(pio_rdata), .pio_status(pio_status), .irq(irq),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model (queues per channel) ----------------
   logic [DW-1:0]  m_tx [NCH][$];
   logic [DW-1:0]  m_rx [NCH][$];
   logic [NCH-1:0] m_ovf = '0;
   logic [NCH-1:0] m_set;
   logic           m_primed = 1'b0;
   logic [2:0]     m_hist = 3'b000;
   logic [2:0]     m_e;
   logic           m_ack = 1'b0, m_bad = 1'b0, m_irq = 1'b0, m_good;
   logic [DW-1:0]  m_rdata = '0;
   logic [2:0]     m_st = 3'b000;
   int             m_a;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_tx[c].delete();
            m_rx[c].delete();
         end
         m_ovf = '0; m_primed = 1'b0; m_hist = 3'b000;
         m_ack = 1'b0; m_bad = 1'b0; m_irq = 1'b0; m_rdata = '0; m_st = 3'b000;
      end else begin
         m_e      = m_primed ? (cmd ^ m_hist) : 3'b000;
         m_hist   = cmd;
         m_primed = 1'b1;
         m_a      = int'(addr);
         m_good   = (m_a < NCH);
         m_set    = '0;
         // streams drain first, so a full FIFO being popped can take a push
         for (int c = 0; c < NCH; c++)
            if (m_tx[c].size() > 0 && tx_ready[c]) void'(m_tx[c].pop_front());
         if (m_e[0] && m_good) begin
            if (m_tx[m_a].size() < DEPTH) m_tx[m_a].push_back(wdata);
            else m_set[m_a] = 1'b1;
         end
         if (m_e[1] && m_good) begin
            if (m_rx[m_a].size() > 0) m_rdata = m_rx[m_a].pop_front();
            else m_rdata = '0;
         end
         for (int c = 0; c < NCH; c++) begin
            if (rx_valid[c]) begin
               if (m_rx[c].size() < DEPTH) m_rx[c].push_back(rx_data[c*DW +: DW]);
               else m_set[c] = 1'b1;
            end
         end
         if (m_e[2] && m_good) m_ovf[m_a] = 1'b0;
         m_ovf = m_ovf | m_set;
         if (m_e != 3'b000) begin
            m_ack = ~m_ack;
            m_bad = ~m_good;
         end
         m_st = 3'b000;
         if (m_good)
            m_st = {m_ovf[m_a], m_tx[m_a].size() == DEPTH, m_rx[m_a].size() != 0};
         m_irq = 1'b0;
         for (int c = 0; c < NCH; c++)
            if (m_rx[c].size() != 0) m_irq = 1'b1;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NCH-1:0] ev;
         cmp("status", 32'(pio_status), 32'({m_bad, m_st, m_ack}));
         cmp("rdata", 32'(pio_rdata), 32'(m_rdata));
         cmp("irq", 32'(irq), 32'(m_irq));
         ev = '0;
         for (int c = 0; c < NCH; c++) begin
            ev[c] = (m_tx[c].size() > 0);
            if (m_tx[c].size() > 0)
               cmp("tx_data", 32'(tx_data[c*DW +: DW]), 32'(m_tx[c][0]));
         end
         cmp("tx_valid", 32'(tx_valid), 32'(ev));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic toggle(input logic [2:0] b);
      cmd = cmd ^ b;
      ack_lit = ~ack_lit;
      tick();
   endtask

   task automatic strobe(input int ch, input logic [DW-1:0] v);
      rx_valid = '0;
      rx_valid[ch] = 1'b1;
      rx_data[ch*DW +: DW] = v;
      tick();
      rx_valid = '0;
   endtask

   initial begin
      // Reset with read+write flags already high
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      cmp("rst_status", 32'(pio_status), 32'd0);
      cmp("rst_rdata", 32'(pio_rdata), 32'd0);
      cmp("rst_irq", 32'(irq), 32'd0);
      cmp("rst_txv", 32'(tx_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      cmp("prime_ack", 32'(pio_status[0]), 32'd0);
      cmp("prime_txv", 32'(tx_valid), 32'd0);
      addr = 2'd0; wdata = 8'h11;
      toggle(3'b001);
      cmp("first_wr_status", 32'(pio_status), 32'b00001);
      cmp("first_wr_txv", 32'(tx_valid), 32'b001);
      cmp("first_wr_txd", 32'(tx_data[7:0]), 32'h11);
      tx_ready = 3'b001; tick(); tx_ready = '0;
      cmp("first_drain", 32'(tx_valid), 32'd0);

      // Single byte on channel 2 held until accepted
      addr = 2'd2; wdata = 8'hA5;
      toggle(3'b001);
      cmp("ch2_ack", 32'(pio_status[0]), 32'(ack_lit));
      cmp("ch2_txv", 32'(tx_valid), 32'b100);
      cmp("ch2_txd", 32'(tx_data[23:16]), 32'hA5);
      tick(); tick();
      cmp("ch2_hold", 32'(tx_data[23:16]), 32'hA5);
      tx_ready = 3'b100; tick(); tx_ready = '0;
      cmp("ch2_drain", 32'(tx_valid), 32'd0);

      // Channel 1 RX overflow, full drain, clear
      addr = 2'd1;
      for (int i = 0; i < 17; i++) strobe(1, 8'(i));
      cmp("ovf_irq", 32'(irq), 32'd1);
      cmp("ovf_status", 32'(pio_status), 32'({1'b0, 3'b101, ack_lit}));
      for (int i = 0; i < 16; i++) begin
         toggle(3'b010);
         cmp("rd_seq", 32'(pio_rdata), 32'(i));
      end
      toggle(3'b010);
      cmp("rd_empty", 32'(pio_rdata), 32'd0);
      cmp("rd_empty_ne", 32'(pio_status[1]), 32'd0);
      toggle(3'b100);
      cmp("clr_ovf", 32'(pio_status[3]), 32'd0);
      cmp("clr_irq", 32'(irq), 32'd0);

      // Channel 0: full RX with same-cycle strobe and read
      addr = 2'd0;
      for (int i = 0; i < 16; i++) strobe(0, 8'(8'h40 + i));
      rx_valid = 3'b001; rx_data[7:0] = 8'h99;
      toggle(3'b010);
      rx_valid = '0;
      cmp("simul_rdata", 32'(pio_rdata), 32'h40);
      cmp("simul_ovf", 32'(pio_status[3]), 32'd0);
      for (int i = 0; i < 16; i++) toggle(3'b010);
      cmp("simul_last", 32'(pio_rdata), 32'h99);
      toggle(3'b010);
      cmp("simul_empty", 32'(pio_rdata), 32'h00);

      // Bad address
      addr = 2'd3; wdata = 8'h77;
      toggle(3'b001);
      cmp("bad_set", 32'(pio_status[4]), 32'd1);
      cmp("bad_ack", 32'(pio_status[0]), 32'(ack_lit));
      cmp("bad_txv", 32'(tx_valid), 32'd0);
      addr = 2'd0;
      toggle(3'b010);
      cmp("bad_clr", 32'(pio_status[4]), 32'd0);

      // All three commands together on channel 0
      for (int i = 0; i < 17; i++) strobe(0, 8'(8'h60 + i));
      wdata = 8'hC3;
      toggle(3'b111);
      cmp("all3_ack", 32'(pio_status[0]), 32'(ack_lit));
      cmp("all3_txd", 32'(tx_data[7:0]), 32'hC3);
      cmp("all3_rdata", 32'(pio_rdata), 32'h60);
      cmp("all3_ovf", 32'(pio_status[3]), 32'd0);
      strobe(0, 8'h71);
      rx_valid = 3'b001; rx_data[7:0] = 8'h72;
      toggle(3'b100);
      rx_valid = '0;
      cmp("clr_loses", 32'(pio_status[3]), 32'd1);
      toggle(3'b100);
      cmp("clr_again", 32'(pio_status[3]), 32'd0);
      tx_ready = 3'b001; tick(); tx_ready = '0;

      // Channel 1 TX full with a simultaneous pop
      addr = 2'd1;
      for (int i = 0; i < 16; i++) begin
         wdata = 8'(8'h80 + i);
         toggle(3'b001);
      end
      cmp("tx_full", 32'(pio_status[2]), 32'd1);
      tx_ready = 3'b010; wdata = 8'hEE;
      toggle(3'b001);
      cmp("tx_full_pop_ovf", 32'(pio_status[3]), 32'd0);
      for (int i = 0; i < 20; i++) tick();
      tx_ready = '0;

      // Reset in the middle of traffic, released with flags set
      addr = 2'd2; wdata = 8'h3C;
      strobe(2, 8'h21);
      toggle(3'b001);
      rst_n = 1'b0;
      #1;
      cmp("midrst_status", 32'(pio_status), 32'd0);
      cmp("midrst_irq", 32'(irq), 32'd0);
      cmp("midrst_txv", 32'(tx_valid), 32'd0);
      ack_lit = 1'b0;
      cmd = cmd ^ 3'b101;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      cmp("reprime_ack", 32'(pio_status[0]), 32'd0);
      toggle(3'b001);
      cmp("reprime_txv", 32'(tx_valid), 32'b100);
      cmp("reprime_txd", 32'(tx_data[23:16]), 32'h3C);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
